// File: rtl/sm4_pkg.sv
// Shared SM4 definitions: client FSM encoding, linear-transform rotation
// amounts, mode encoding and a 32-bit rotate helper.
package sm4_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_COLLECT = 2'd2,
        ST_OUT     = 2'd3
    } state_e;

    typedef enum logic {
        MODE_L  = 1'b0,
        MODE_LP = 1'b1
    } mode_e;

    localparam int unsigned ROT_L0  = 2;
    localparam int unsigned ROT_L1  = 10;
    localparam int unsigned ROT_L2  = 18;
    localparam int unsigned ROT_L3  = 24;
    localparam int unsigned ROT_LP0 = 13;
    localparam int unsigned ROT_LP1 = 23;

    function automatic logic [31:0] rol32(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

endpackage

// File: rtl/sm4_l_xform.sv
// SM4 linear transform: L for the data round, L' for key expansion.
// Purely combinational so round and key-expansion paths can share it.
module sm4_l_xform
    import sm4_pkg::*;
(
    input  logic [31:0] data,
    input  logic        mode,
    output logic [31:0] result
);

    always_comb begin
        if (mode == MODE_LP) begin
            result = data ^ rol32(data, ROT_LP0) ^ rol32(data, ROT_LP1);
        end else begin
            result = data ^ rol32(data, ROT_L0) ^ rol32(data, ROT_L1)
                          ^ rol32(data, ROT_L2) ^ rol32(data, ROT_L3);
        end
    end

endmodule

// File: rtl/sm4_tau_client.sv
// Serialises one word's bytes to a shared byte-wide S_Box, reassembles the
// substituted word (tau) and returns L or L' of it with a collect timeout.
module sm4_tau_client
    import sm4_pkg::*;
#(
    parameter int TIMEOUT_CYC = 15,
    parameter int CNT_W       = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_data,
    input  logic        i_mode,
    input  logic        i_valid,
    output logic        o_ready,
    output logic [7:0]  o_sbox_data,
    output logic        o_sbox_valid,
    input  logic [7:0]  i_sbox_data,
    input  logic        i_sbox_valid,
    output logic [31:0] o_data,
    output logic        o_valid,
    input  logic        i_ready,
    output logic        o_err
);

    state_e            state_q, state_d;
    logic [31:0]       word_q;
    logic              mode_q;
    logic [1:0]        byte_cnt_q;
    logic [2:0]        resp_cnt_q;
    logic [31:0]       tau_q, tau_next;
    logic [CNT_W-1:0]  tmo_q;
    logic              ready_q, valid_q, err_q;
    logic [31:0]       data_q, l_out;
    logic              accept, timeout, finish, resp_take, all_done;

    // Responses count only while a transaction is in flight, and at most four.
    assign resp_take = i_sbox_valid && !resp_cnt_q[2]
                    && (state_q == ST_SEND || state_q == ST_COLLECT);
    assign all_done  = resp_cnt_q[2] || (resp_take && resp_cnt_q[1:0] == 2'd3);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        tau_next = tau_q;
        if (resp_take) begin
            case (resp_cnt_q[1:0])
                2'd0:    tau_next[31:24] = i_sbox_data;
                2'd1:    tau_next[23:16] = i_sbox_data;
                2'd2:    tau_next[15:8]  = i_sbox_data;
                default: tau_next[7:0]   = i_sbox_data;
            endcase
        end
    end

    always_comb begin
        o_sbox_data = 8'h00;
        if (state_q == ST_SEND) begin
            case (byte_cnt_q)
                2'd0:    o_sbox_data = word_q[31:24];
                2'd1:    o_sbox_data = word_q[23:16];
                2'd2:    o_sbox_data = word_q[15:8];
                default: o_sbox_data = word_q[7:0];
            endcase
        end
    end

    // The transform sees the word including a byte arriving this cycle.
    sm4_l_xform u_l_xform (
        .data   (tau_next),
        .mode   (mode_q),
        .result (l_out)
    );

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        timeout = 1'b0;
        finish  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_valid && ready_q) begin
                    accept  = 1'b1;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (byte_cnt_q == 2'd3) state_d = ST_COLLECT;
            end
            ST_COLLECT: begin
                if (all_done) begin
                    finish  = 1'b1;
                    state_d = ST_OUT;
                end else if (tmo_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    timeout = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_OUT: begin
                if (i_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            word_q     <= '0;
            mode_q     <= 1'b0;
            byte_cnt_q <= '0;
            resp_cnt_q <= '0;
            tau_q      <= '0;
            tmo_q      <= '0;
            ready_q    <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == ST_IDLE);
            err_q   <= timeout;
            if (accept) begin
                word_q     <= i_data;
                mode_q     <= i_mode;
                byte_cnt_q <= '0;
                resp_cnt_q <= '0;
                tau_q      <= '0;
                tmo_q      <= '0;
            end
            if (state_q == ST_SEND) byte_cnt_q <= byte_cnt_q + 2'd1;
            if (resp_take) begin
                tau_q      <= tau_next;
                resp_cnt_q <= resp_cnt_q + 3'd1;
            end
            if (state_q == ST_COLLECT) tmo_q <= tmo_q + CNT_W'(1);
            if (finish) begin
                data_q  <= l_out;
                valid_q <= 1'b1;
            end
            if (state_q == ST_OUT && i_ready) valid_q <= 1'b0;
        end
    end

    assign o_ready      = ready_q;
    assign o_sbox_valid = (state_q == ST_SEND);
    assign o_data       = data_q;
    assign o_valid      = valid_q;
    assign o_err        = err_q;

endmodule

// File: tb/tb_sm4_tau_client.sv
// Directed bench for sm4_tau_client with a 1-cycle S_Box responder model.
module tb_sm4_tau_client;

    localparam int TIMEOUT_CYC = 15;
    localparam int CNT_W       = 4;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [31:0] i_data = '0;
    logic        i_mode = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [7:0]  o_sbox_data;
    logic        o_sbox_valid;
    logic [7:0]  i_sbox_data = '0;
    logic        i_sbox_valid = 1'b0;
    logic [31:0] o_data;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic        o_err;

    int n_checks = 0;
    int n_err    = 0;
    int sbox_limit = 4;
    int burst_idx  = 0;

    sm4_tau_client #(.TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_data       (i_data),
        .i_mode       (i_mode),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .o_sbox_data  (o_sbox_data),
        .o_sbox_valid (o_sbox_valid),
        .i_sbox_data  (i_sbox_data),
        .i_sbox_valid (i_sbox_valid),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_err        (o_err)
    );

    always #5 i_clk = ~i_clk;

    // Partial SM4 S_Box: only the entries the vectors below use.
    function automatic logic [7:0] sbox_ref(input logic [7:0] b);
        case (b)
            8'h00:   return 8'hD6;
            8'h01:   return 8'h90;
            8'h02:   return 8'hE9;
            8'h03:   return 8'hFE;
            8'h04:   return 8'hCC;
            8'h05:   return 8'hE1;
            8'hFF:   return 8'h48;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] tau_ref(input logic [31:0] x);
        return {sbox_ref(x[31:24]), sbox_ref(x[23:16]), sbox_ref(x[15:8]), sbox_ref(x[7:0])};
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        logic [63:0] dd;
        dd = {x, x};
        return dd[63-n -: 32];
    endfunction

    function automatic logic [31:0] ref_l(input logic [31:0] b, input logic m);
        if (m) return b ^ rotl(b, 13) ^ rotl(b, 23);
        return b ^ rotl(b, 2) ^ rotl(b, 10) ^ rotl(b, 18) ^ rotl(b, 24);
    endfunction

    // S_Box responder: one-cycle latency, answers only the first sbox_limit
    // bytes of each burst.
    always @(posedge i_clk) begin
        burst_idx    <= o_sbox_valid ? burst_idx + 1 : 0;
        i_sbox_valid <= o_sbox_valid && (burst_idx < sbox_limit);
        i_sbox_data  <= sbox_ref(o_sbox_data);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int waited = 0;
        while (!o_ready && waited < 20) begin
            @(negedge i_clk);
            waited++;
        end
        check({tag, "_ready"}, 32'(o_ready), 32'd1);
    endtask

    // Accepts a word at cycle T and returns at the negedge of cycle T+6.
    task automatic run_word(input logic [31:0] d, input logic m,
                            input logic [31:0] exp, input string tag);
        wait_ready(tag);
        i_data  = d;
        i_mode  = m;
        i_valid = 1'b1;
        @(negedge i_clk);
        i_valid = 1'b0;
        check({tag, "_busy"}, 32'(o_ready), 32'd0);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge i_clk);
            check($sformatf("%s_sbv%0d", tag, k), 32'(o_sbox_valid), 32'd1);
            check($sformatf("%s_sbd%0d", tag, k), 32'(o_sbox_data), 32'(d[31-8*k -: 8]));
        end
        @(negedge i_clk);
        check({tag, "_sbv_off"}, 32'(o_sbox_valid), 32'd0);
        check({tag, "_early"}, 32'(o_valid), 32'd0);
        @(negedge i_clk);
        check({tag, "_valid"}, 32'(o_valid), 32'd1);
        check({tag, "_data"}, o_data, exp);
    endtask

    task automatic expect_idle(input string tag);
        @(negedge i_clk);
        check({tag, "_vdrop"}, 32'(o_valid), 32'd0);
        check({tag, "_rdy"}, 32'(o_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] hold_val;
        int err_cnt;
        int valid_seen;

        // Reset
        repeat (2) @(negedge i_clk);
        check("rst_ready", 32'(o_ready), 32'd0);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_data", o_data, 32'd0);
        check("rst_err", 32'(o_err), 32'd0);
        check("rst_sbv", 32'(o_sbox_valid), 32'd0);
        check("rst_sbd", 32'(o_sbox_data), 32'd0);
        i_rst = 1'b0;
        @(negedge i_clk);
        check("post_rst_ready", 32'(o_ready), 32'd1);

        // 1, 2: all-zero word in both modes
        run_word(32'h0000_0000, 1'b0, 32'h5B5B_5B5B, "zero_l");
        expect_idle("zero_l");
        run_word(32'h0000_0000, 1'b1, 32'h6767_6767, "zero_lp");
        expect_idle("zero_lp");

        // 3: mixed bytes, tau checked on the assembled register
        run_word(32'h0001_02FF, 1'b0, ref_l(tau_ref(32'h0001_02FF), 1'b0), "mixed");
        check("mixed_tau", dut.tau_q, 32'hD690_E948);
        expect_idle("mixed");

        // 4: backpressure with a competing input word
        i_ready = 1'b0;
        hold_val = ref_l(tau_ref(32'h0102_0304), 1'b0);
        run_word(32'h0102_0304, 1'b0, hold_val, "bp");
        i_data  = 32'h0505_0505;
        i_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge i_clk);
            check($sformatf("bp_hold_v%0d", c), 32'(o_valid), 32'd1);
            check($sformatf("bp_hold_d%0d", c), o_data, hold_val);
            check($sformatf("bp_hold_r%0d", c), 32'(o_ready), 32'd0);
            check($sformatf("bp_hold_s%0d", c), 32'(o_sbox_valid), 32'd0);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        expect_idle("bp");
        @(negedge i_clk);
        check("bp_no_send", 32'(o_sbox_valid), 32'd0);

        // 5: S_Box stub answers only two bytes
        sbox_limit = 2;
        wait_ready("tmo");
        i_data  = 32'h0001_0203;
        i_mode  = 1'b0;
        i_valid = 1'b1;
        err_cnt = 0;
        valid_seen = 0;
        for (int c = 1; c <= 21; c++) begin
            @(negedge i_clk);
            i_valid = 1'b0;
            check($sformatf("tmo_err_c%0d", c), 32'(o_err), 32'(c == TIMEOUT_CYC + 5));
            if (o_err) err_cnt++;
            if (o_valid) valid_seen++;
        end
        check("tmo_err_once", 32'(err_cnt), 32'd1);
        check("tmo_no_valid", 32'(valid_seen), 32'd0);
        check("tmo_ready", 32'(o_ready), 32'd1);
        sbox_limit = 4;
        run_word(32'h0001_02FF, 1'b1, ref_l(tau_ref(32'h0001_02FF), 1'b1), "after_tmo");
        expect_idle("after_tmo");

        // 6: reset at T+3 of a transaction
        wait_ready("rst_mid");
        i_data  = 32'h0304_0500;
        i_mode  = 1'b1;
        i_valid = 1'b1;
        @(negedge i_clk);
        i_valid = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        check("mid_rst_ready", 32'(o_ready), 32'd0);
        check("mid_rst_sbv", 32'(o_sbox_valid), 32'd0);
        check("mid_rst_sbd", 32'(o_sbox_data), 32'd0);
        check("mid_rst_valid", 32'(o_valid), 32'd0);
        check("mid_rst_data", o_data, 32'd0);
        check("mid_rst_err", 32'(o_err), 32'd0);
        check("mid_rst_late_resp", 32'(i_sbox_valid), 32'd1);
        @(negedge i_clk);
        check("mid_rst_ready2", 32'(o_ready), 32'd1);
        check("mid_rst_err2", 32'(o_err), 32'd0);
        check("mid_rst_resp_cnt", 32'(dut.resp_cnt_q), 32'd0);
        run_word(32'h0304_0500, 1'b1, ref_l(tau_ref(32'h0304_0500), 1'b1), "after_rst");
        expect_idle("after_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
